// File: rtl/cla_16_addsub_pipe.sv
// Three-stage pipelined 16-bit adder/subtractor using four 4-bit
// lookahead slices and a second-level lookahead carry unit.
module cla_16_addsub_pipe (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        sub,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] s,
    output logic        c_out,
    output logic        ovf,
    output logic        zero
);

    // Slice sum with internal lookahead; MSB is the carry into bit 3.
    function automatic logic [4:0] slice_sum(
        input logic [3:0] x,
        input logic [3:0] y,
        input logic       ci
    );
        logic [3:0] pp;
        logic [3:0] gg;
        logic [3:0] cc;
        pp    = x ^ y;
        gg    = x & y;
        cc[0] = ci;
        cc[1] = gg[0] | (pp[0] & ci);
        cc[2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & ci);
        cc[3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
              | (pp[2] & pp[1] & pp[0] & ci);
        return {cc[3], pp ^ cc};
    endfunction

    logic        v1, v2, v3;
    logic        adv1, adv2, adv3;

    logic [15:0] a1, bx1;
    logic        cin1;

    logic [15:0] a2, bx2;
    logic        cin2;
    logic [3:0]  p2, g2;

    logic [15:0] pb, gb;
    logic [3:0]  p_n, g_n;

    logic [4:0]  blk_c;
    logic [4:0]  sl0, sl1, sl2, sl3;
    logic [15:0] s_n;

    assign adv3     = v2 & (~v3 | out_ready);
    assign adv2     = v1 & (~v2 | adv3);
    assign in_ready = ~v1 | adv2;
    assign adv1     = in_valid & in_ready;
    assign out_valid = v3;

    // Block propagate/generate for each 4-bit slice of stage 1.
    always_comb begin
        pb  = a1 ^ bx1;
        gb  = a1 & bx1;
        p_n = '0;
        g_n = '0;
        for (int k = 0; k < 4; k++) begin
            p_n[k] = &pb[4*k +: 4];
            g_n[k] = gb[4*k+3]
                   | (pb[4*k+3] & gb[4*k+2])
                   | (pb[4*k+3] & pb[4*k+2] & gb[4*k+1])
                   | (pb[4*k+3] & pb[4*k+2] & pb[4*k+1] & gb[4*k]);
        end
    end

    // Second-level lookahead carries and per-slice sums for stage 3.
    always_comb begin
        blk_c[0] = cin2;
        blk_c[1] = g2[0] | (p2[0] & cin2);
        blk_c[2] = g2[1] | (p2[1] & g2[0]) | (p2[1] & p2[0] & cin2);
        blk_c[3] = g2[2] | (p2[2] & g2[1]) | (p2[2] & p2[1] & g2[0])
                 | (p2[2] & p2[1] & p2[0] & cin2);
        blk_c[4] = g2[3] | (p2[3] & g2[2]) | (p2[3] & p2[2] & g2[1])
                 | (p2[3] & p2[2] & p2[1] & g2[0])
                 | (p2[3] & p2[2] & p2[1] & p2[0] & cin2);
        sl0 = slice_sum(a2[3:0],   bx2[3:0],   blk_c[0]);
        sl1 = slice_sum(a2[7:4],   bx2[7:4],   blk_c[1]);
        sl2 = slice_sum(a2[11:8],  bx2[11:8],  blk_c[2]);
        sl3 = slice_sum(a2[15:12], bx2[15:12], blk_c[3]);
        s_n = {sl3[3:0], sl2[3:0], sl1[3:0], sl0[3:0]};
    end

    // Stage 1: operand register with conditional inversion of b.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1   <= 1'b0;
            a1   <= '0;
            bx1  <= '0;
            cin1 <= 1'b0;
        end else begin
            v1 <= adv1 | (v1 & ~adv2);
            if (adv1) begin
                a1   <= a;
                bx1  <= b ^ {16{sub}};
                cin1 <= sub;
            end
        end
    end

    // Stage 2: block p/g register plus forwarded operands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2   <= 1'b0;
            a2   <= '0;
            bx2  <= '0;
            cin2 <= 1'b0;
            p2   <= '0;
            g2   <= '0;
        end else begin
            v2 <= adv2 | (v2 & ~adv3);
            if (adv2) begin
                a2   <= a1;
                bx2  <= bx1;
                cin2 <= cin1;
                p2   <= p_n;
                g2   <= g_n;
            end
        end
    end

    // Stage 3: result register, held while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v3    <= 1'b0;
            s     <= '0;
            c_out <= 1'b0;
            ovf   <= 1'b0;
            zero  <= 1'b0;
        end else begin
            v3 <= adv3 | (v3 & ~out_ready);
            if (adv3) begin
                s     <= s_n;
                c_out <= blk_c[4];
                ovf   <= sl3[4] ^ blk_c[4];
                zero  <= (s_n == 16'h0000);
            end
        end
    end

endmodule

// File: tb/tb_cla_16_addsub_pipe.sv
// Scoreboard bench for cla_16_addsub_pipe: directed vectors,
// expected {s, c_out, ovf, zero} queued at issue, checked by a monitor.
module tb_cla_16_addsub_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a, b;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] s;
    logic        c_out, ovf, zero;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [18:0] exp_q[$];
    int          pop_cyc[$];

    cla_16_addsub_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .c_out     (c_out),
        .ovf       (ovf),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    function automatic logic [18:0] pack(input logic [15:0] sv,
                                         input logic c, input logic o);
        return {sv, c, o, (sv == 16'h0000)};
    endfunction

    // Behavioural reference: plain integer arithmetic, sign rule for ovf.
    function automatic logic [18:0] model(input logic [15:0] x,
                                          input logic [15:0] y,
                                          input logic sb);
        logic [16:0] r;
        logic [15:0] yy;
        logic        o;
        yy = sb ? ~y : y;
        r  = {1'b0, x} + {1'b0, yy} + {16'h0, sb};
        o  = (x[15] == yy[15]) && (r[15] != x[15]);
        return pack(r[15:0], r[16], o);
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // Monitor: pop and compare on every output transfer.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_result: got %h want none",
                         {s, c_out, ovf, zero});
            end else begin
                logic [18:0] e;
                e = exp_q.pop_front();
                if ({s, c_out, ovf, zero} !== e) begin
                    bad++;
                    $display("FAIL result: got %h want %h",
                             {s, c_out, ovf, zero}, e);
                end
            end
            pop_cyc.push_back(cyc);
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accept edge.
    task automatic send(input logic [15:0] x, input logic [15:0] y,
                        input logic sb, input logic [18:0] e);
        int guard;
        guard    = 0;
        a        = x;
        b        = y;
        sub      = sb;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            guard++;
            if (guard > 100) begin
                $display("FAIL accept_timeout: got stalled want accept");
                bad++;
                total++;
                break;
            end
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 100) begin
            @(posedge clk);
            guard++;
        end
        #1;
        check("drain", exp_q.size(), 0);
    endtask

    logic [15:0] va[8];
    logic [15:0] vb[8];
    logic        vs[8];
    logic [15:0] frz;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        sub       = 1'b0;
        out_ready = 1'b1;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_s", s, 0);
        check("rst_flags", {c_out, ovf, zero}, 0);
        check("rst_in_ready", in_ready, 1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        send(16'h1234, 16'h0FFF, 1'b0, pack(16'h2233, 1'b0, 1'b0));
        check("lat_e0", out_valid, 0);
        @(posedge clk);
        #1;
        check("lat_e1", out_valid, 0);
        @(posedge clk);
        #1;
        check("lat_e2", out_valid, 1);
        drain();

        send(16'h7FFF, 16'h0001, 1'b0, pack(16'h8000, 1'b0, 1'b1));
        send(16'h8000, 16'h0001, 1'b1, pack(16'h7FFF, 1'b1, 1'b1));
        send(16'h0000, 16'h0001, 1'b1, pack(16'hFFFF, 1'b0, 1'b0));
        send(16'hFFFF, 16'h0001, 1'b0, pack(16'h0000, 1'b1, 1'b0));
        drain();

        va = '{16'h0001, 16'hABCD, 16'h8000, 16'h7FFF,
               16'h00FF, 16'hF0F0, 16'h0000, 16'h4000};
        vb = '{16'h0002, 16'h1234, 16'h7FFF, 16'hFFFF,
               16'h0F01, 16'h0F10, 16'h8000, 16'h4000};
        vs = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        pop_cyc.delete();
        for (int i = 0; i < 8; i++)
            send(va[i], vb[i], vs[i], model(va[i], vb[i], vs[i]));
        drain();
        check("b2b_count", pop_cyc.size(), 8);
        for (int i = 1; i < 8 && i < pop_cyc.size(); i++)
            check("b2b_gap", pop_cyc[i] - pop_cyc[i-1], 1);

        out_ready = 1'b0;
        send(16'h0010, 16'h0020, 1'b0, pack(16'h0030, 1'b0, 1'b0));
        send(16'h0100, 16'h0001, 1'b1, pack(16'h00FF, 1'b1, 1'b0));
        send(16'h8000, 16'h8000, 1'b0, pack(16'h0000, 1'b1, 1'b1));
        frz = 16'h0030;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_ready", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
            check("bp_frozen_s", s, frz);
        end
        fork
            begin
                send(16'h1111, 16'h2222, 1'b0,
                     pack(16'h3333, 1'b0, 1'b0));
                send(16'h5555, 16'h5555, 1'b1,
                     pack(16'h0000, 1'b1, 1'b0));
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        send(16'h0101, 16'h0202, 1'b0, pack(16'h0303, 1'b0, 1'b0));
        send(16'h0404, 16'h0505, 1'b0, pack(16'h0909, 1'b0, 1'b0));
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_s", s, 0);
        check("mid_rst_flags", {c_out, ovf, zero}, 0);
        check("mid_rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no_stale", out_valid, 0);
        end
        @(posedge clk);
        #1;
        send(16'h0001, 16'h0001, 1'b0, pack(16'h0002, 1'b0, 1'b0));
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
